instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of the ArithmeticLogicUnit execute path: owns the 16-bit program counter, fetches instruction words from instruction memory over a req/ack handshake, and buffers them in a small FIFO. Each buffered word is presented with its PC to the decode/execute stage over a valid/ready handshake. A single-cycle redirect from downstream flushes the FIFO, and fetch restarts at a new PC.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/instr_fetch_unit.sv | 111 +++++++++++
 tb/tb_instr_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: widths, fetch FSM states and the buffered fetch entry.
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int ENTRY_W = PC_W + INSTR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Word-addressed PC; wraps from all-ones to zero.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding {pc, instr} fetch entries; flush beats push and pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]               cnt_q;
    logic                        do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is cleared on reset so the head reads as zero before the first fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one-outstanding imem requests and buffers words
// for decode; a redirect flushes the buffer and drains any in-flight request.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t        state_q, state_d;
    logic [PC_W-1:0]     fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]     drain_pc_q, drain_pc_d;
    logic                xfer, push, pop, full, empty;
    logic [CW-1:0]       count, count_nxt;
    fetch_entry_t        wr_entry, head;
    logic [ENTRY_W-1:0]  head_raw;

    assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr = (state_q == DRAIN) ? drain_pc_q : fetch_pc_q;

    assign xfer      = imem_req && imem_ack;
    assign push      = xfer && (state_q == REQ) && !redirect;
    assign pop       = instr_valid && instr_ready && !redirect;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign wr_entry  = '{pc: fetch_pc_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .flush (redirect),
        .rdata (head_raw),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign head        = fetch_entry_t'(head_raw);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign instr_valid = !empty;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drain_pc_d = drain_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            unique case (state_q)
                IDLE:  state_d = halt ? IDLE : REQ;
                REQ: begin
                    if (imem_ack) begin
                        state_d = halt ? IDLE : REQ;
                    end else begin
                        // Memory still owes us a word; hold its address until it arrives.
                        state_d    = DRAIN;
                        drain_pc_d = fetch_pc_q;
                    end
                end
                DRAIN: if (imem_ack) state_d = halt ? IDLE : REQ;
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: if (!full && !halt) state_d = REQ;
                REQ: begin
                    if (imem_ack) begin
                        fetch_pc_d = pc_inc(fetch_pc_q);
                        state_d    = (count_nxt < CW'(DEPTH) && !halt) ? REQ : IDLE;
                    end
                end
                DRAIN: if (imem_ack) state_d = halt ? IDLE : REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            drain_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drain_pc_q <= drain_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, directed corner sequences and a random
// run scored against a queue-based model of the fetch stream.
module tb_instr_fetch_unit;

    localparam logic [15:0] KEY   = 16'hA5C3;
    localparam int          DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        ack_en = 1'b0, instr_ready = 1'b0, redirect = 1'b0, halt = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        imem_req, imem_ack, instr_valid;
    logic [15:0] imem_addr, imem_rdata, instr, instr_pc;

    logic        ack2_en = 1'b0, ready2 = 1'b0, redirect2 = 1'b0, halt2 = 1'b0;
    logic [15:0] rpc2 = 16'h0;
    logic        req2, ack2, valid2;
    logic [15:0] addr2, rdata2, instr2, pc2;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ KEY;
    endfunction

    assign imem_ack   = imem_req && ack_en;
    assign imem_rdata = mem_word(imem_addr);
    assign ack2       = req2 && ack2_en;
    assign rdata2     = mem_word(addr2);

    instr_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFE), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2), .instr(instr2), .instr_pc(pc2),
        .instr_valid(valid2), .instr_ready(ready2), .redirect(redirect2),
        .redirect_pc(rpc2), .halt(halt2)
    );

    int n_chk = 0, n_fail = 0, pops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stream of words decode should see, as a queue.
    typedef struct packed { logic [15:0] pc; logic [15:0] data; } ent_t;
    ent_t        q[$];
    logic [15:0] exp_pc = 16'h0, stale_pc = 16'h0;
    logic        stale = 1'b0, pend = 1'b0;

    task automatic model_pre();
        pend = 1'b0;
        if (reset) begin
            q.delete();
            exp_pc = 16'h0000;
            stale  = 1'b0;
        end else begin
            pend = imem_req && !imem_ack;
            if (imem_req) chk("imem_addr", imem_addr, stale ? stale_pc : exp_pc);
            if (redirect) begin
                q.delete();
                if (imem_req && !imem_ack) begin
                    if (!stale) begin
                        stale    = 1'b1;
                        stale_pc = exp_pc;
                    end
                end else begin
                    stale = 1'b0;
                end
                exp_pc = redirect_pc;
            end else begin
                if (instr_valid && instr_ready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    pops++;
                end
                if (imem_req && imem_ack) begin
                    if (stale) stale = 1'b0;
                    else begin
                        q.push_back({exp_pc, mem_word(exp_pc)});
                        exp_pc = exp_pc + 16'd1;
                    end
                end
            end
        end
    endtask

    task automatic model_post();
        chk("valid_vs_model", instr_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("pc_vs_model", instr_pc, q[0].pc);
            chk("instr_vs_model", instr, q[0].data);
        end
        chk("fifo_bound", q.size() <= DEPTH, 1);
        if (pend) chk("req_held", imem_req, 1);
    endtask

    task automatic tick();
        #1;
        model_pre();
        @(posedge clk);
        #1;
        model_post();
    endtask

    typedef struct {
        logic        rst, ack, rdy;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_vld, hd;
        logic [15:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rst, ack, rdy, req, input logic [15:0] addr,
                                input logic vld, hd, input logic [15:0] pc);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdy = rdy; v.e_req = req; v.e_addr = addr;
        v.e_vld = vld; v.hd = hd; v.e_pc = pc;
        return v;
    endfunction

    localparam int NV = 14;
    vec_t tv[NV];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] wrap_pc[3];

        // Reset, zero-wait streaming, then a 5-cycle downstream stall.
        tv[0]  = mk(1, 0, 1, 0, 16'h0, 0, 1, 16'h0);
        tv[1]  = mk(0, 1, 1, 1, 16'h0, 0, 0, 16'h0);
        tv[2]  = mk(0, 1, 1, 1, 16'h1, 1, 1, 16'h0);
        tv[3]  = mk(0, 1, 1, 1, 16'h2, 1, 1, 16'h1);
        tv[4]  = mk(0, 1, 1, 1, 16'h3, 1, 1, 16'h2);
        tv[5]  = mk(0, 1, 1, 1, 16'h4, 1, 1, 16'h3);
        for (int i = 6; i <= 10; i++) tv[i] = mk(0, 1, 0, 0, 16'h5, 1, 1, 16'h3);
        tv[11] = mk(0, 1, 1, 0, 16'h5, 1, 1, 16'h4);
        tv[12] = mk(0, 1, 1, 1, 16'h5, 0, 0, 16'h0);
        tv[13] = mk(0, 1, 1, 1, 16'h6, 1, 1, 16'h5);

        for (int i = 0; i < NV; i++) begin
            reset = tv[i].rst; ack_en = tv[i].ack; instr_ready = tv[i].rdy;
            tick();
            chk($sformatf("v%0d_req", i), imem_req, tv[i].e_req);
            chk($sformatf("v%0d_addr", i), imem_addr, tv[i].e_addr);
            chk($sformatf("v%0d_valid", i), instr_valid, tv[i].e_vld);
            if (tv[i].hd) begin
                chk($sformatf("v%0d_pc", i), instr_pc, tv[i].e_pc);
                chk($sformatf("v%0d_instr", i), instr, tv[i].e_vld ? mem_word(tv[i].e_pc) : 16'h0);
            end
        end

        // Redirect while a 3-wait-state request for 0x0004 is pending.
        reset = 1'b1; ack_en = 1'b1; instr_ready = 1'b1; tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr == 16'h0004) break;
            tick();
        end
        chk("reach_pc4", {imem_req, imem_addr}, {1'b1, 16'h0004});
        ack_en = 1'b0; tick();
        chk("wait_addr", imem_addr, 16'h0004);
        redirect = 1'b1; redirect_pc = 16'h0100; tick();
        redirect = 1'b0;
        chk("drain_req", imem_req, 1);
        chk("drain_addr", imem_addr, 16'h0004);
        chk("drain_flush", instr_valid, 0);
        tick();
        chk("drain_hold", imem_addr, 16'h0004);
        ack_en = 1'b1; tick();
        chk("post_drain_addr", {imem_req, imem_addr}, {1'b1, 16'h0100});
        chk("post_drain_valid", instr_valid, 0);
        tick();
        chk("first_pc_after_flush", {instr_valid, instr_pc}, {1'b1, 16'h0100});
        chk("first_instr_after_flush", instr, mem_word(16'h0100));

        // Redirect coinciding with an ack and a pop.
        reset = 1'b1; tick();
        reset = 1'b0; tick(); tick(); tick();
        chk("pre_redir_state", {instr_valid, imem_req}, 2'b11);
        redirect = 1'b1; redirect_pc = 16'h0200; tick();
        redirect = 1'b0;
        chk("redir_ack_valid", instr_valid, 0);
        chk("redir_ack_addr", imem_addr, 16'h0200);
        tick();
        chk("redir_ack_pc", {instr_valid, instr_pc}, {1'b1, 16'h0200});

        // RESET_PC near the top of the address space: wrap, halt, reset mid-request.
        wrap_pc[0] = 16'hFFFE; wrap_pc[1] = 16'hFFFF; wrap_pc[2] = 16'h0000;
        reset = 1'b1; tick();
        reset = 1'b0; ack2_en = 1'b1; ready2 = 1'b1; halt2 = 1'b0; tick();
        chk("wrap_first_req", {req2, addr2}, {1'b1, 16'hFFFE});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("wrap_pc%0d", i), {valid2, pc2}, {1'b1, wrap_pc[i]});
        end
        ack2_en = 1'b0; halt2 = 1'b1; tick();
        chk("halt_pending_req", {req2, addr2}, {1'b1, 16'h0001});
        tick();
        chk("halt_pending_req2", req2, 1);
        ack2_en = 1'b1; tick();
        chk("halt_after_ack", req2, 0);
        tick();
        chk("halt_stays_idle", req2, 0);
        halt2 = 1'b0; ack2_en = 1'b0; tick();
        chk("resume_req", req2, 1);
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("rst_req", req2, 0);
        chk("rst_addr", addr2, 16'hFFFE);
        chk("rst_valid", valid2, 0);
        chk("rst_instr", instr2, 16'h0000);
        chk("rst_pc", pc2, 16'h0000);

        // Random traffic against the stream model.
        reset = 1'b1; tick();
        reset = 1'b0;
        pops = 0;
        for (int c = 0; c < 3000; c++) begin
            ack_en      = ($urandom_range(0, 9) < 6);
            instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            tick();
        end
        redirect = 1'b0; halt = 1'b0;
        chk("liveness", pops > 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
